fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RV32I pipeline. It owns the program counter, issues reads to the instruction memory port, and presents one {PC, instruction} pair per accepted transfer to the IF/ID pipeline registers, which shift on `load`. It absorbs variable memory latency, downstream stalls and branch/jump redirects, and discards in-flight responses made stale by a redirect.

## Interface
- `RESET_PC`, default 32'h0000_0060: PC value loaded on reset.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `ready_i` in 1: pipeline accepts the pair this cycle; drives the pipeline registers' `load`.
- `redirect_i` in 1: taken branch/jump resolved; fetch restarts at `redirect_pc_i`.
- `redirect_pc_i` in 32: redirect target, word-aligned.
- `imem_read` out 1: instruction read request.
- `imem_address` out 32: read address, always equal to the internal PC.
- `imem_resp` in 1: one-cycle read-complete pulse.
- `imem_rdata` in 32: instruction word, valid when `imem_resp` is high.
- `valid_o` out 1: `pc_o`/`instr_o` hold a fetched instruction.
- `pc_o` out 32: PC of the presented instruction.
- `instr_o` out 32: presented instruction word.

## Operation
- State `fetch_state_t`: FETCH (request outstanding), HOLD (instruction buffered, waiting for `ready_i`), FLUSH (stale request outstanding).
- `imem_read` = 1 in FETCH and FLUSH, 0 in HOLD and during reset. Address is held stable until `imem_resp`.
- FETCH: on `imem_resp`, the instruction buffer loads `imem_rdata` and the state goes to HOLD. Without `imem_resp`, the state stays FETCH.
- HOLD: `valid_o` = 1. If `ready_i` is high: PC <= PC + 4 (modulo 2^32, carry dropped), state goes to FETCH.
- Redirect has priority over `ready_i` and `imem_resp` in every state. It loads PC <= `redirect_pc_i` and clears the buffer.
  - FETCH with no `imem_resp` -> FLUSH.
  - FETCH with `imem_resp` in the same cycle -> FETCH; the data is discarded.
  - HOLD -> FETCH; `ready_i` is ignored. The consumer treats any same-cycle transfer as squashed.
  - FLUSH -> FLUSH; PC is overwritten again.
- FLUSH: `imem_resp` is discarded, then the state goes to FETCH. A new request to the current PC is issued the next cycle.
- A transfer occurs only when `valid_o && ready_i && !redirect_i`.

## Timing
- During reset and in the cycle it is sampled: PC = `RESET_PC`, state = FETCH, buffer = 0.
- Reset-cycle outputs: `imem_read` = 0, `valid_o` = 0, `pc_o` = `RESET_PC`, `instr_o` = 0.
- First cycle after reset deasserts: `imem_read` = 1, `imem_address` = `RESET_PC`.
- Reset mid-request abandons the request. Memory must tolerate a dropped `imem_read`.
- Registered path, `imem_resp` in cycle N:
  - `valid_o` = 1 in cycle N+1.
  - If `ready_i` is high in N+1, the next request is issued in N+2.
  - Best-case throughput: one instruction per (memory latency + 2) cycles.
- `pc_o` = PC register. `instr_o` = buffer, or bypass data (see Configuration).
- `valid_o` never glitches high in FLUSH or in a redirect cycle.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - In FETCH with `imem_resp` and no redirect, `valid_o` = 1 combinationally and `instr_o` = `imem_rdata`.
  - If `ready_i` is also high: PC <= PC + 4, state stays FETCH, and the next request is issued in N+1 (throughput: latency + 1).
  - If `ready_i` is low: the data is buffered and the state goes to HOLD.
- `FETCH_BYPASS_EN` undefined: outputs are purely registered, as described in Timing. No combinational path exists from `imem_*` to `valid_o`/`instr_o`.

## Structure
- `fetch_state_t` enum (FETCH, HOLD, FLUSH) and `PC_STRIDE` = 4 go in `rv32i_types`.
- Sub-module: `pc_reg`, a 32-bit register with synchronous reset-to-parameter and a load-enable mux (increment or redirect). The FSM and instruction buffer are inline.

## Test plan
- Reset, 1-cycle memory, `ready_i` tied 1 -> `imem_address` sequence 0x60, 0x64, 0x68. `valid_o` pulses carry matching `pc_o`; `instr_o` equals the memory contents.
- `ready_i` low for 5 cycles while in HOLD at PC 0x64 -> `valid_o`, `pc_o`, `instr_o` stable. `imem_read` = 0. No PC change until `ready_i` rises.
- `redirect_i` to 0x200 two cycles into a 4-cycle read of 0x60 -> FLUSH. The 0x60 response is dropped with `valid_o` = 0. The next request is to 0x200.
- `redirect_i` to 0x300 in the same cycle as `imem_resp` and `ready_i` -> data discarded, `valid_o` = 0 in the following cycle, next address 0x300.
- PC 0xFFFF_FFFC accepted -> next `imem_address` = 0x0000_0000.
- With `FETCH_BYPASS_EN`, 1-cycle memory, `ready_i` = 1 -> `valid_o` high every other cycle, `instr_o` = `imem_rdata` in the response cycle. Without it, `valid_o` is high every third cycle.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared RV32I pipeline types: fetch FSM states and the sequential PC stride.
package rv32i_types;

    localparam logic [31:0] PC_STRIDE = 32'd4;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        FLUSH
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: synchronous reset to RESET_PC, redirect load beats increment.
module pc_reg
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        load,
    input  logic [31:0] load_pc,
    output logic [31:0] pc
);

    logic [31:0] value_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            value_reg <= RESET_PC;
        end else if (load) begin
            value_reg <= load_pc;
        end else if (inc) begin
            value_reg <= value_reg + PC_STRIDE;
        end
    end

    assign pc = value_reg;

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: PC ownership, imem requests, redirect flushing.
// Optional feature macro: FETCH_BYPASS_EN (forward imem_rdata straight to the IF/ID pair).
module fetch_unit
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  instr_reg, instr_next;
    logic         pc_inc;
    logic         pc_load;
    logic [31:0]  pc;
    logic         bypass_hit;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .reset   (reset),
        .inc     (pc_inc),
        .load    (pc_load),
        .load_pc (redirect_pc_i),
        .pc      (pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FETCH;
            instr_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            instr_reg <= instr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        instr_next = instr_reg;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        case (state_reg)
            FETCH: begin
                if (redirect_i) begin
                    // A response landing in the redirect cycle is already stale.
                    pc_load    = 1'b1;
                    instr_next = 32'd0;
                    state_next = imem_resp ? FETCH : FLUSH;
                end else if (imem_resp) begin
`ifdef FETCH_BYPASS_EN
                    if (ready_i) begin
                        pc_inc = 1'b1;
                    end else begin
                        instr_next = imem_rdata;
                        state_next = HOLD;
                    end
`else
                    instr_next = imem_rdata;
                    state_next = HOLD;
`endif
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    pc_load    = 1'b1;
                    instr_next = 32'd0;
                    state_next = FETCH;
                end else if (ready_i) begin
                    pc_inc     = 1'b1;
                    state_next = FETCH;
                end
            end
            FLUSH: begin
                if (redirect_i) begin
                    pc_load    = 1'b1;
                    instr_next = 32'd0;
                end else if (imem_resp) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = !reset && (state_reg == FETCH) && imem_resp && !redirect_i;
`else
    assign bypass_hit = 1'b0;
`endif

    assign imem_read    = !reset && (state_reg != HOLD);
    assign imem_address = pc;
    assign valid_o      = (!reset && (state_reg == HOLD) && !redirect_i) || bypass_hit;
    assign pc_o         = pc;
    assign instr_o      = bypass_hit ? imem_rdata : instr_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a fixed-latency memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] instr_o;

    int checks_count = 0;
    int fail_count   = 0;
    int mem_lat      = 1;
    int wait_cnt     = 0;

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .ready_i       (ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_read     (imem_read),
        .imem_address  (imem_address),
        .imem_resp     (imem_resp),
        .imem_rdata    (imem_rdata),
        .valid_o       (valid_o),
        .pc_o          (pc_o),
        .instr_o       (instr_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0], ~addr[15:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_count++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Apply this cycle's inputs; memory answers once the request has waited mem_lat cycles.
    task automatic drive(input logic rdy, input logic redir, input logic [31:0] rpc);
        ready_i       = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        #1;
        imem_resp  = imem_read && (wait_cnt == mem_lat);
        imem_rdata = imem_resp ? mem_word(imem_address) : 32'hDEAD_BEEF;
        #1;
    endtask

    task automatic tick();
        if (imem_read) wait_cnt = imem_resp ? 0 : wait_cnt + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat);
        reset   = 1'b1;
        mem_lat = lat;
        drive(1'b0, 1'b0, 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'd0);
        tick();
        wait_cnt = 0;
        reset    = 1'b0;
    endtask

    // Leaves the bench in the cycle where valid_o is first seen high (not yet ticked).
    task automatic run_until_valid(input logic rdy);
        bit seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            drive(rdy, 1'b0, 32'd0);
            if (valid_o) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check_eq("valid_within_budget", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        reset         = 1'b1;
        ready_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        imem_resp     = 1'b0;
        imem_rdata    = 32'd0;

        // Reset state, checked while reset is still asserted.
        mem_lat = 1;
        drive(1'b0, 1'b0, 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'd0);
        check_eq("rst_imem_read", {31'd0, imem_read}, 32'd0);
        check_eq("rst_valid", {31'd0, valid_o}, 32'd0);
        check_eq("rst_pc", pc_o, 32'h0000_0060);
        check_eq("rst_instr", instr_o, 32'd0);
        tick();
        reset    = 1'b0;
        wait_cnt = 0;

        // Straight-line fetch with 1-cycle memory and ready tied high.
        for (int i = 0; i < 9; i++) begin
            logic        e_read, e_valid;
            logic [31:0] e_pc;
`ifdef FETCH_BYPASS_EN
            e_read  = 1'b1;
            e_valid = (i % 2) == 1;
            e_pc    = 32'h60 + 32'(4 * (i / 2));
`else
            e_read  = (i % 3) != 2;
            e_valid = (i % 3) == 2;
            e_pc    = 32'h60 + 32'(4 * (i / 3));
`endif
            drive(1'b1, 1'b0, 32'd0);
            check_eq($sformatf("seq%0d_read", i), {31'd0, imem_read}, {31'd0, e_read});
            check_eq($sformatf("seq%0d_valid", i), {31'd0, valid_o}, {31'd0, e_valid});
            if (e_read) check_eq($sformatf("seq%0d_addr", i), imem_address, e_pc);
            if (e_valid) begin
                check_eq($sformatf("seq%0d_pc", i), pc_o, e_pc);
                check_eq($sformatf("seq%0d_instr", i), instr_o, mem_word(e_pc));
            end
            tick();
        end

        // Stall in HOLD at PC 0x64.
        do_reset(1);
        run_until_valid(1'b1);
        check_eq("stall_first_pc", pc_o, 32'h60);
        tick();
        run_until_valid(1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 32'd0);
            check_eq($sformatf("stall%0d_valid", i), {31'd0, valid_o}, 32'd1);
            check_eq($sformatf("stall%0d_pc", i), pc_o, 32'h64);
            check_eq($sformatf("stall%0d_instr", i), instr_o, mem_word(32'h64));
            check_eq($sformatf("stall%0d_read", i), {31'd0, imem_read}, 32'd0);
            tick();
        end
        drive(1'b1, 1'b0, 32'd0);
        check_eq("stall_release_valid", {31'd0, valid_o}, 32'd1);
        tick();
        drive(1'b0, 1'b0, 32'd0);
        check_eq("stall_next_read", {31'd0, imem_read}, 32'd1);
        check_eq("stall_next_addr", imem_address, 32'h68);
        tick();

        // Redirect to 0x200 two cycles into a 4-cycle read of 0x60.
        do_reset(4);
        drive(1'b1, 1'b0, 32'd0);
        check_eq("flush_c0_addr", imem_address, 32'h60);
        tick();
        drive(1'b1, 1'b0, 32'd0);
        tick();
        drive(1'b1, 1'b1, 32'h200);
        check_eq("flush_redir_valid", {31'd0, valid_o}, 32'd0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 32'd0);
            check_eq($sformatf("flush%0d_valid", i), {31'd0, valid_o}, 32'd0);
            check_eq($sformatf("flush%0d_addr", i), imem_address, 32'h200);
            tick();
        end
        drive(1'b1, 1'b0, 32'd0);
        check_eq("flush_refetch_read", {31'd0, imem_read}, 32'd1);
        check_eq("flush_refetch_addr", imem_address, 32'h200);
        check_eq("flush_refetch_valid", {31'd0, valid_o}, 32'd0);
        tick();
        run_until_valid(1'b1);
        check_eq("flush_target_pc", pc_o, 32'h200);
        check_eq("flush_target_instr", instr_o, mem_word(32'h200));
        tick();

        // Redirect to 0x300 coinciding with imem_resp and ready.
        do_reset(1);
        drive(1'b1, 1'b0, 32'd0);
        tick();
        drive(1'b1, 1'b1, 32'h300);
        check_eq("same_resp_seen", {31'd0, imem_resp}, 32'd1);
        check_eq("same_redir_valid", {31'd0, valid_o}, 32'd0);
        tick();
        drive(1'b1, 1'b0, 32'd0);
        check_eq("same_next_valid", {31'd0, valid_o}, 32'd0);
        check_eq("same_next_read", {31'd0, imem_read}, 32'd1);
        check_eq("same_next_addr", imem_address, 32'h300);
        tick();
        run_until_valid(1'b1);
        check_eq("same_target_pc", pc_o, 32'h300);
        tick();

        // PC wraparound from 0xFFFF_FFFC.
        do_reset(1);
        drive(1'b0, 1'b1, 32'hFFFF_FFFC);
        tick();
        drive(1'b0, 1'b0, 32'd0);
        check_eq("wrap_flush_valid", {31'd0, valid_o}, 32'd0);
        tick();
        run_until_valid(1'b0);
        check_eq("wrap_pc", pc_o, 32'hFFFF_FFFC);
        tick();
        drive(1'b1, 1'b0, 32'd0);
        check_eq("wrap_accept_valid", {31'd0, valid_o}, 32'd1);
        tick();
        drive(1'b0, 1'b0, 32'd0);
        check_eq("wrap_next_read", {31'd0, imem_read}, 32'd1);
        check_eq("wrap_next_addr", imem_address, 32'h0000_0000);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks_count, fail_count);
        $finish;
    end

endmodule
